// File: rtl/alu_op_issue.sv
// alu_op_issue: execute-stage issue buffer between ID/EX and the 64-bit ALU.
// Decodes {class, funct3, funct7[5]} into a 4-bit ALU code plus branch sense,
// and feeds the ALU from a registered 2-entry skid buffer (output reg + skid reg).
// Illegal encodings are delivered with out_illegal=1 and counted (saturating).
// Optional feature: define ALU_ISSUE_SLT_EN to map R-type SLT (funct3 010,
// funct7[5]=0) onto the compare code instead of treating it as illegal.
module alu_op_issue #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_alu_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7_5,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_aluop,
    output logic              out_zero_inv,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_CMP = 4'b1111;

    typedef struct packed {
        logic [3:0]        aluop;
        logic              inv;
        logic              illegal;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        rd;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    entry_t           out_q, out_d, skid_q, skid_d, dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q;
    logic             accept, out_hs;

    // Input-side decode; illegal encodings leave aluop/inv at zero.
    always_comb begin
        dec         = '0;
        dec.a       = in_a;
        dec.b       = in_b;
        dec.rd      = in_rd;
        dec.illegal = 1'b0;
        case (in_alu_class)
            2'b00: dec.aluop = OP_ADD;
            2'b01: begin
                case (in_funct3)
                    3'b000: dec.aluop = OP_SUB;
                    3'b001: begin dec.aluop = OP_SUB; dec.inv = 1'b1; end
                    3'b100: dec.aluop = OP_CMP;
                    3'b101: begin dec.aluop = OP_CMP; dec.inv = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            2'b10: begin
                case ({in_funct3, in_funct7_5})
                    4'b000_0: dec.aluop = OP_ADD;
                    4'b000_1: dec.aluop = OP_SUB;
                    4'b111_0: dec.aluop = OP_AND;
                    4'b110_0: dec.aluop = OP_OR;
`ifdef ALU_ISSUE_SLT_EN
                    4'b010_0: dec.aluop = OP_CMP;
`endif
                    default:  dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready_q;
    assign out_hs = (state_q != EMPTY) & out_ready;

    // Next-state, entry movement and illegal-op counting.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    out_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (out_hs && out_q.illegal && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
        if (flush) begin
            state_d = EMPTY;
            out_d   = '0;
            skid_d  = '0;
            cnt_d   = cnt_q;
        end
    end

    // State, entries, counter and registered in_ready; reset beats flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != EMPTY);
    assign out_aluop     = out_q.aluop;
    assign out_zero_inv  = out_q.inv;
    assign out_illegal   = out_q.illegal;
    assign out_a         = out_q.a;
    assign out_b         = out_q.b;
    assign out_rd        = out_q.rd;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: a queue-based reference model of the
// 2-deep FIFO plus a name-based decode table, compared every cycle, plus
// hand-computed literal checks for the directed scenarios.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_funct7_5;
    logic [1:0]  in_alu_class;
    logic [2:0]  in_funct3;
    logic [63:0] in_a, in_b, out_a, out_b;
    logic [4:0]  in_rd, out_rd;
    logic        out_valid, out_ready, out_zero_inv, out_illegal;
    logic [3:0]  out_aluop;
    logic [7:0]  illegal_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alu_op_issue #(.DATA_W(64), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_class(in_alu_class), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluop(out_aluop), .out_zero_inv(out_zero_inv),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        inv;
        logic        ill;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t mq[$];
    int   mcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, written instruction-by-instruction.
    function automatic exp_t ref_dec(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                                     input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        exp_t e;
        bit slt_en;
`ifdef ALU_ISSUE_SLT_EN
        slt_en = 1'b1;
`else
        slt_en = 1'b0;
`endif
        e.a = a; e.b = b; e.rd = rd;
        e.op = 4'h0; e.inv = 1'b0; e.ill = 1'b1;
        if (cls == 2'd0) begin e.op = 4'h2; e.ill = 1'b0; end                 // load/store
        else if (cls == 2'd1) begin
            if (f3 == 3'd0)      begin e.op = 4'h6; e.ill = 1'b0; end             // BEQ
            else if (f3 == 3'd1) begin e.op = 4'h6; e.inv = 1'b1; e.ill = 1'b0; end // BNE
            else if (f3 == 3'd4) begin e.op = 4'hF; e.ill = 1'b0; end             // BLT
            else if (f3 == 3'd5) begin e.op = 4'hF; e.inv = 1'b1; e.ill = 1'b0; end // BGE
        end else if (cls == 2'd2) begin
            if (f3 == 3'd0)                begin e.op = f7 ? 4'h6 : 4'h2; e.ill = 1'b0; end
            else if (f3 == 3'd7 && !f7)    begin e.op = 4'h0; e.ill = 1'b0; end
            else if (f3 == 3'd6 && !f7)    begin e.op = 4'h1; e.ill = 1'b0; end
            else if (f3 == 3'd2 && !f7 && slt_en) begin e.op = 4'hF; e.ill = 1'b0; end
        end
        return e;
    endfunction

    // Model update at each rising edge from the inputs the DUT sampled.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mcnt = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            int sz;
            sz = mq.size();
            if (sz > 0 && out_ready) begin
                if (mq[0].ill && mcnt < 255) mcnt++;
                void'(mq.pop_front());
            end
            if (in_valid && sz < 2)
                mq.push_back(ref_dec(in_alu_class, in_funct3, in_funct7_5, in_a, in_b, in_rd));
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, mq.size() < 2);
            chk("illegal_count", illegal_count, mcnt);
            if (mq.size() > 0) begin
                chk("out_aluop", out_aluop, mq[0].op);
                chk("out_zero_inv", out_zero_inv, mq[0].inv);
                chk("out_illegal", out_illegal, mq[0].ill);
                chk("out_a", out_a, mq[0].a);
                chk("out_b", out_b, mq[0].b);
                chk("out_rd", out_rd, mq[0].rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        in_valid = v; in_alu_class = cls; in_funct3 = f3; in_funct7_5 = f7;
        in_a = a; in_b = b; in_rd = rd;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 1'b0, 64'd5, 64'd6, 5'd1);
        step(); step();
        reset = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
        chk_en = 1'b1;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_aluop", out_aluop, 0);
        chk("rst count", illegal_count, 0);
        chk("rst out_a", out_a, 0);

        // R-type SUB
        out_ready = 1'b1;
        drive(1'b1, 2'd2, 3'd0, 1'b1, 64'd10, 64'd3, 5'd7);
        step();
        chk("sub valid", out_valid, 1);
        chk("sub aluop", out_aluop, 4'b0110);
        chk("sub a", out_a, 10);
        chk("sub b", out_b, 3);
        chk("sub illegal", out_illegal, 0);
        // BGE then BNE
        drive(1'b1, 2'd1, 3'd5, 1'b0, 64'd1, 64'd2, 5'd0);
        step();
        chk("bge aluop", out_aluop, 4'b1111);
        chk("bge inv", out_zero_inv, 1);
        drive(1'b1, 2'd1, 3'd1, 1'b0, 64'd1, 64'd2, 5'd0);
        step();
        chk("bne aluop", out_aluop, 4'b0110);
        chk("bne inv", out_zero_inv, 1);
        // SLT encoding
        drive(1'b1, 2'd2, 3'd2, 1'b0, 64'd4, 64'd9, 5'd3);
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
`ifdef ALU_ISSUE_SLT_EN
        chk("slt aluop", out_aluop, 4'b1111);
        chk("slt illegal", out_illegal, 0);
        step();
        chk("slt count", illegal_count, 0);
`else
        chk("slt aluop", out_aluop, 4'b0000);
        chk("slt illegal", out_illegal, 1);
        step();
        chk("slt count", illegal_count, 1);
`endif
        step();

        // Stall: three pushes with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 1'b0, 64'd1, 64'd11, 5'd1);
        step();
        drive(1'b1, 2'd0, 3'd0, 1'b0, 64'd2, 64'd12, 5'd2);
        step();
        chk("stall in_ready", in_ready, 0);
        chk("stall head", out_a, 1);
        drive(1'b1, 2'd0, 3'd0, 1'b0, 64'd3, 64'd13, 5'd3);
        step();
        chk("stall hold", out_a, 1);
        chk("stall rd", out_rd, 1);
        out_ready = 1'b1;
        step();
        chk("drain 2", out_a, 2);
        chk("drain ready", in_ready, 1);
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
        chk("drain 3", out_a, 3);
        chk("drain 3 valid", out_valid, 1);
        step();
        chk("drain empty", out_valid, 0);

        // Saturation of the illegal counter
        drive(1'b1, 2'd3, 3'd0, 1'b0, 64'd8, 64'd9, 5'd4);
        for (int i = 0; i < 300; i++) step();
        chk("sat illegal", out_illegal, 1);
        chk("sat aluop", out_aluop, 0);
        drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
        step();
        chk("sat count", illegal_count, 255);

        // Flush from FULL with a simultaneous input
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 1'b0, 64'd21, 64'd0, 5'd1);
        step();
        drive(1'b1, 2'd0, 3'd0, 1'b0, 64'd22, 64'd0, 5'd2);
        step();
        chk("pre-flush in_ready", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 2'd0, 3'd0, 1'b0, 64'd77, 64'd0, 5'd9);
        step();
        flush = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
        chk("flush valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("flush stays empty", out_valid, 0);

        // Randomized traffic, with occasional flush and reset
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 31)));
            step();
        end
        reset = 1'b0; flush = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
